// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Define ADDI_EN to add the addi execute/writeback states (codes 11/12).
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        RTYPE_EX = 4'd7,
        RTYPE_WB = 4'd8,
        BEQ      = 4'd9,
`ifdef ADDI_EN
        JUMP     = 4'd10,
        ADDI_EX  = 4'd11,
        ADDI_WB  = 4'd12
`else
        JUMP     = 4'd10
`endif
    } stateT;

    stateT curState;
    stateT nextState;

    always_ff @(posedge clk) begin
        if (reset) begin
            curState <= IDLE;
        end else begin
            curState <= nextState;
        end
    end

    assign state = curState;

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        nextState   = IDLE;

        case (curState)
            IDLE: begin
                nextState = FETCH;
            end

            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b01;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                nextState = mem_ready ? DECODE : FETCH;
            end

            // Branch target is computed speculatively here while the opcode is decoded.
            DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = RTYPE_EX;
                    OP_BEQ:       nextState = BEQ;
                    OP_J:         nextState = JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      nextState = ADDI_EX;
`else
                    OP_ADDI: begin
                        illegal_op = 1'b1;
                        nextState  = FETCH;
                    end
`endif
                    default: begin
                        illegal_op = 1'b1;
                        nextState  = FETCH;
                    end
                endcase
            end

            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nextState = (op == OP_LW) ? MEMRD : MEMWR;
            end

            MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                nextState = mem_ready ? MEMWB : MEMRD;
            end

            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end

            MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                nextState  = mem_ready ? FETCH : MEMWR;
            end

            RTYPE_EX: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                nextState = RTYPE_WB;
            end

            RTYPE_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end

            BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                nextState   = FETCH;
            end

            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                nextState  = FETCH;
            end

`ifdef ADDI_EN
            ADDI_EX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nextState = ADDI_WB;
            end

            ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end
`endif

            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors with hand-computed outputs.
// Build with +define+ADDI_EN to exercise the addi path.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       memReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, instrDone, illegalOp;
    logic [3:0] state;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (memReady),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .PCSource   (PCSource),
        .ALUOp      (ALUOp),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .state      (state),
        .instr_done (instrDone),
        .illegal_op (illegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OPR  = 6'b000000;
    localparam logic [5:0] OPLW = 6'b100011;
    localparam logic [5:0] OPSW = 6'b101011;
    localparam logic [5:0] OPBQ = 6'b000100;
    localparam logic [5:0] OPJ  = 6'b000010;
    localparam logic [5:0] OPAD = 6'b001000;
    localparam logic [5:0] OPXX = 6'b001100;

    // Field order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
    //              PCSource ALUOp ALUSrcA ALUSrcB RegWrite RegDst instr_done illegal_op
    localparam logic [17:0] E_IDLE    = 18'b0_0_0_0_0_0_0_00_00_0_00_0_0_0_0;
    localparam logic [17:0] E_FETCH   = 18'b1_0_0_1_0_1_0_00_00_0_01_0_0_0_0;
    localparam logic [17:0] E_FETCHS  = 18'b0_0_0_1_0_0_0_00_00_0_01_0_0_0_0;
    localparam logic [17:0] E_DEC     = 18'b0_0_0_0_0_0_0_00_00_0_11_0_0_0_0;
    localparam logic [17:0] E_DECILL  = 18'b0_0_0_0_0_0_0_00_00_0_11_0_0_0_1;
    localparam logic [17:0] E_MEMADR  = 18'b0_0_0_0_0_0_0_00_00_1_10_0_0_0_0;
    localparam logic [17:0] E_MEMRD   = 18'b0_0_1_1_0_0_0_00_00_0_00_0_0_0_0;
    localparam logic [17:0] E_MEMWB   = 18'b0_0_0_0_0_0_1_00_00_0_00_1_0_1_0;
    localparam logic [17:0] E_MEMWRS  = 18'b0_0_1_0_1_0_0_00_00_0_00_0_0_0_0;
    localparam logic [17:0] E_MEMWR   = 18'b0_0_1_0_1_0_0_00_00_0_00_0_0_1_0;
    localparam logic [17:0] E_RTEX    = 18'b0_0_0_0_0_0_0_00_10_1_00_0_0_0_0;
    localparam logic [17:0] E_RTWB    = 18'b0_0_0_0_0_0_0_00_00_0_00_1_1_1_0;
    localparam logic [17:0] E_BEQ     = 18'b0_1_0_0_0_0_0_01_01_1_00_0_0_1_0;
    localparam logic [17:0] E_JUMP    = 18'b1_0_0_0_0_0_0_10_00_0_00_0_0_1_0;
    localparam logic [17:0] E_ADDIWB  = 18'b0_0_0_0_0_0_0_00_00_0_00_1_0_1_0;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctl;
        int unsigned id;
    } expT;

    expT         sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned stepId = 0;
    logic [17:0] actCtl;

    assign actCtl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, instrDone, illegalOp};

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            expT e;
            e = sb.pop_front();
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL step%0d state got %0d want %0d", e.id, state, e.st);
            end
            checks++;
            if (actCtl !== e.ctl) begin
                errors++;
                $display("FAIL step%0d ctl got %b want %b", e.id, actCtl, e.ctl);
            end
            checks++;
            if (MemRead && MemWrite) begin
                errors++;
                $display("FAIL step%0d memexcl got rd=%b wr=%b want not both", e.id, MemRead, MemWrite);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] o, input logic m, input logic chk,
                        input logic [3:0] es, input logic [17:0] ec);
        expT e;
        reset    = r;
        op       = o;
        memReady = m;
        if (chk) begin
            e.st  = es;
            e.ctl = ec;
            e.id  = stepId;
            sb.push_back(e);
        end
        stepId++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        op       = '0;
        memReady = 1'b1;
        step(1'b1, OPR, 1'b1, 1'b0, 4'd0, E_IDLE);

        // reset state, then lw
        step(1'b0, OPR,  1'b1, 1'b1, 4'd0, E_IDLE);
        step(1'b0, OPLW, 1'b1, 1'b1, 4'd1, E_FETCH);
        step(1'b0, OPLW, 1'b1, 1'b1, 4'd2, E_DEC);
        step(1'b0, OPLW, 1'b1, 1'b1, 4'd3, E_MEMADR);
        step(1'b0, OPLW, 1'b1, 1'b1, 4'd4, E_MEMRD);
        step(1'b0, OPLW, 1'b1, 1'b1, 4'd5, E_MEMWB);

        // sw with two stall cycles in MEMWR
        step(1'b0, OPSW, 1'b1, 1'b1, 4'd1, E_FETCH);
        step(1'b0, OPSW, 1'b1, 1'b1, 4'd2, E_DEC);
        step(1'b0, OPSW, 1'b1, 1'b1, 4'd3, E_MEMADR);
        step(1'b0, OPSW, 1'b0, 1'b1, 4'd6, E_MEMWRS);
        step(1'b0, OPSW, 1'b0, 1'b1, 4'd6, E_MEMWRS);
        step(1'b0, OPSW, 1'b1, 1'b1, 4'd6, E_MEMWR);

        // R-type, beq, j back to back
        step(1'b0, OPR,  1'b1, 1'b1, 4'd1, E_FETCH);
        step(1'b0, OPR,  1'b1, 1'b1, 4'd2, E_DEC);
        step(1'b0, OPR,  1'b1, 1'b1, 4'd7, E_RTEX);
        step(1'b0, OPR,  1'b1, 1'b1, 4'd8, E_RTWB);
        step(1'b0, OPBQ, 1'b1, 1'b1, 4'd1, E_FETCH);
        step(1'b0, OPBQ, 1'b1, 1'b1, 4'd2, E_DEC);
        step(1'b0, OPBQ, 1'b1, 1'b1, 4'd9, E_BEQ);
        step(1'b0, OPJ,  1'b1, 1'b1, 4'd1, E_FETCH);
        step(1'b0, OPJ,  1'b1, 1'b1, 4'd2, E_DEC);
        step(1'b0, OPJ,  1'b1, 1'b1, 4'd10, E_JUMP);

        // FETCH stalled three cycles, then an illegal opcode
        step(1'b0, OPXX, 1'b0, 1'b1, 4'd1, E_FETCHS);
        step(1'b0, OPXX, 1'b0, 1'b1, 4'd1, E_FETCHS);
        step(1'b0, OPXX, 1'b0, 1'b1, 4'd1, E_FETCHS);
        step(1'b0, OPXX, 1'b1, 1'b1, 4'd1, E_FETCH);
        step(1'b0, OPXX, 1'b1, 1'b1, 4'd2, E_DECILL);

        // addi: legal only when the feature is built in
        step(1'b0, OPAD, 1'b1, 1'b1, 4'd1, E_FETCH);
`ifdef ADDI_EN
        step(1'b0, OPAD, 1'b1, 1'b1, 4'd2, E_DEC);
        step(1'b0, OPAD, 1'b1, 1'b1, 4'd11, E_MEMADR);
        step(1'b0, OPAD, 1'b1, 1'b1, 4'd12, E_ADDIWB);
`else
        step(1'b0, OPAD, 1'b1, 1'b1, 4'd2, E_DECILL);
`endif

        // lw interrupted by reset while in MEMRD; reset wins over mem_ready
        step(1'b0, OPLW, 1'b1, 1'b1, 4'd1, E_FETCH);
        step(1'b0, OPLW, 1'b1, 1'b1, 4'd2, E_DEC);
        step(1'b0, OPLW, 1'b1, 1'b1, 4'd3, E_MEMADR);
        step(1'b0, OPLW, 1'b0, 1'b1, 4'd4, E_MEMRD);
        step(1'b1, OPLW, 1'b1, 1'b1, 4'd4, E_MEMRD);
        step(1'b0, OPLW, 1'b1, 1'b1, 4'd0, E_IDLE);
        step(1'b0, OPLW, 1'b1, 1'b1, 4'd1, E_FETCH);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style control FSM that sequences the multicycle MIPS datapath (shared memory, IR, A/B/ALUOut registers) through fetch/decode/execute/memory/writeback steps. It replaces the single-cycle opcode decoder with per-state control. It decodes R-type, lw, sw, beq and j. Opcode `op` comes from the datapath IR. A `mem_ready` handshake stalls memory states.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_J, 6'b000010, jump opcode
OP_ADDI, 6'b001000, addi opcode (used only with ADDI_EN)

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high
op  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read
MemWrite  out  1  memory write
IRWrite  out  1  IR load
MemtoReg  out  1  1=MDR to register file
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
RegWrite  out  1  register file write
RegDst  out  1  1=rd, 0=rt
state  out  4  current state encoding (debug)
instr_done  out  1  one-cycle pulse, instruction retires
illegal_op  out  1  one-cycle pulse, unrecognised opcode in DECODE

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPE_EX=7, RTYPE_WB=8, BEQ=9, JUMP=10, ADDI_EX=11, ADDI_WB=12. Codes 13-15 are unreachable and go to IDLE.
- Reset: reset=1 at an edge sets state to IDLE, overriding any in-flight instruction. It wins over mem_ready.
- In IDLE every output is 0. This includes all control outputs, instr_done, illegal_op, and state=0.
- IDLE goes to FETCH unconditionally on the next edge.
- Outputs are decoded combinationally from state, plus mem_ready where noted. Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are both equal to mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by op: lw/sw go to MEMADR, R-type to RTYPE_EX, beq to BEQ, j to JUMP.
  - Any other op: illegal_op=1 and next state is FETCH (instruction treated as NOP; PC already advanced).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD if op=lw, otherwise MEMWR.
- MEMRD: MemRead=1, IorD=1. Waits on mem_ready, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Goes to FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - MemWrite stays high while waiting for mem_ready.
  - When mem_ready=1: instr_done=1 and next state is FETCH.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RTYPE_WB.
- RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Goes to FETCH.
- Latency with mem_ready held at 1: lw 5 cycles, sw 4, R-type 4, beq 3, j 3. Each memory state adds one cycle per cycle of mem_ready=0.
- Never assert MemRead and MemWrite in the same cycle.
- Never assert RegWrite outside the writeback states.

Optional Feature:
ADDI_EN:
- Defined: DECODE with op=OP_ADDI goes to ADDI_EX (ALUSrcA=1, ALUSrcB=10, ALUOp=00), then ADDI_WB (RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1), then FETCH. addi latency is 4 cycles.
- Undefined: states 11/12 do not exist and are treated as unreachable codes (next state IDLE). OP_ADDI raises illegal_op like any other unknown opcode.

Test Plan:
- Reset then lw (op=6'b100011), mem_ready=1 → state sequence 0,1,2,3,4,5,1. MemtoReg=RegWrite=1 only in state 5; instr_done is pulsed once.
- sw (6'b101011), mem_ready low for 2 cycles in MEMWR → stays in state 6 for 3 cycles with MemWrite=1 throughout. instr_done is 1 only on the last of those cycles.
- R-type, then beq, then j back to back → states 1,2,7,8, then 1,2,9, then 1,2,10. PCWriteCond=1 only in state 9 with ALUOp=01; PCSource=10 in state 10.
- FETCH with mem_ready low for 3 cycles → IRWrite=PCWrite=0 for 3 cycles, then 1 for one cycle, then DECODE.
- op=6'b001100 in DECODE → illegal_op pulses, next state FETCH, no MemWrite/RegWrite asserted. With ADDI_EN, op=6'b001000 follows 1,2,11,12,1 and does not raise illegal_op.
- reset asserted in MEMRD → state=0 next cycle with all outputs 0, then FETCH.
